// File: rtl/ob_mk_ctrl.sv
// ob_mk_ctrl: command sequencer in front of the market-order deque (ob_mk_deque).
// It enqueues incoming market orders, and it drains the deque head against a match
// request while emitting one fill per cycle. Before draining, an all-or-none match is
// checked against the deque's running total quantity. When the head is only partly
// consumed, it is popped and the residual is pushed back to the front.
//
// Entry layout (table_t, 48 bits): [47:32] id, [31:16] price, [15:0] quantity.
// quantity_t is 16 bits and accum_quantity_t is 24 bits.
// deque_op_t encoding: 0 PushBack, 1 PushFront, 2 PopBack (never issued), 3 PopFront.
//
// Ports:
//   clk, rst_n                    clock; synchronous active-low reset
//   ord_vld/ord_data/ord_rdy      market order input (PushBack on ord_vld & ord_rdy)
//   mat_vld/mat_quantity/mat_aon  match request; mat_rdy is high when idle
//   fill_vld/fill_data            one fill per cycle; quantity field = filled amount
//   rsp_vld/rsp_reject/rsp_remain match completion pulse with AON reject and remainder
//   mk_cmd_vld/op/push_data       deque command port (one command per cycle at most)
//   mk_head_vld_r/mk_head_r/mk_empty_w/mk_full_w/mk_quantity_r  deque status
//
// Optional build macro OB_MK_CTRL_STATS_EN adds 32-bit wrapping counters:
//   stat_fills_r, stat_rejects_r, stat_orders_r.

module ob_mk_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ord_vld,
  input  logic [47:0] ord_data,
  output logic        ord_rdy,
  input  logic        mat_vld,
  input  logic [15:0] mat_quantity,
  input  logic        mat_aon,
  output logic        mat_rdy,
  output logic        fill_vld,
  output logic [47:0] fill_data,
  output logic        rsp_vld,
  output logic        rsp_reject,
  output logic [15:0] rsp_remain,
  output logic        mk_cmd_vld,
  output logic [1:0]  mk_cmd_op,
  output logic [47:0] mk_cmd_push_data,
  input  logic        mk_head_vld_r,
  input  logic [47:0] mk_head_r,
  input  logic        mk_empty_w,
  input  logic        mk_full_w,
  input  logic [23:0] mk_quantity_r
`ifdef OB_MK_CTRL_STATS_EN
  ,
  output logic [31:0] stat_fills_r,
  output logic [31:0] stat_rejects_r,
  output logic [31:0] stat_orders_r
`endif
);

  localparam logic [1:0] OpPushBack  = 2'd0;
  localparam logic [1:0] OpPushFront = 2'd1;
  localparam logic [1:0] OpPopFront  = 2'd3;

  typedef enum logic [2:0] {StIdle, StCheck, StDrain, StRepush, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        aon_q, aon_d;
  logic        reject_q, reject_d;
  logic [47:0] residual_q, residual_d;

  logic [15:0] head_qty;
  logic [15:0] rem_after;
  assign head_qty  = mk_head_r[15:0];
  assign rem_after = remaining_q - head_qty;

  always_comb begin
    state_d          = state_q;
    remaining_d      = remaining_q;
    aon_d            = aon_q;
    reject_d         = reject_q;
    residual_d       = residual_q;
    ord_rdy          = 1'b0;
    mat_rdy          = 1'b0;
    fill_vld         = 1'b0;
    fill_data        = '0;
    rsp_vld          = 1'b0;
    rsp_reject       = reject_q;
    rsp_remain       = remaining_q;
    mk_cmd_vld       = 1'b0;
    mk_cmd_op        = OpPushBack;
    mk_cmd_push_data = '0;

    unique case (state_q)
      StIdle: begin
        mat_rdy = 1'b1;
        // A pending match request takes precedence over order entry.
        ord_rdy = ~mat_vld & ~mk_full_w;
        if (mat_vld) begin
          remaining_d = mat_quantity;
          aon_d       = mat_aon;
          reject_d    = 1'b0;
          state_d     = StCheck;
        end else if (ord_vld && ord_rdy) begin
          mk_cmd_vld       = 1'b1;
          mk_cmd_op        = OpPushBack;
          mk_cmd_push_data = ord_data;
        end
      end
      StCheck: begin
        if (aon_q && ({8'd0, remaining_q} > mk_quantity_r)) begin
          reject_d = 1'b1;
          state_d  = StDone;
        end else if (remaining_q == 16'd0 || mk_empty_w) begin
          state_d = StDone;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mk_empty_w || !mk_head_vld_r) begin
          state_d = StDone;
        end else begin
          mk_cmd_vld = 1'b1;
          mk_cmd_op  = OpPopFront;
          fill_vld   = 1'b1;
          if (head_qty <= remaining_q) begin
            fill_data   = mk_head_r;
            remaining_d = rem_after;
            // Stop when satisfied, or when this head was the last queued quantity.
            if (rem_after == 16'd0 || mk_quantity_r == {8'd0, head_qty}) begin
              state_d = StDone;
            end
          end else begin
            fill_data   = {mk_head_r[47:16], remaining_q};
            residual_d  = {mk_head_r[47:16], head_qty - remaining_q};
            remaining_d = 16'd0;
            state_d     = StRepush;
          end
        end
      end
      StRepush: begin
        mk_cmd_vld       = 1'b1;
        mk_cmd_op        = OpPushFront;
        mk_cmd_push_data = residual_q;
        state_d          = StDone;
      end
      StDone: begin
        rsp_vld = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Nothing is offered or issued while reset is asserted.
    if (!rst_n) begin
      ord_rdy    = 1'b0;
      mat_rdy    = 1'b0;
      fill_vld   = 1'b0;
      rsp_vld    = 1'b0;
      mk_cmd_vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      aon_q       <= 1'b0;
      reject_q    <= 1'b0;
      residual_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      aon_q       <= aon_d;
      reject_q    <= reject_d;
      residual_q  <= residual_d;
    end
  end

`ifdef OB_MK_CTRL_STATS_EN
  logic [31:0] fills_q, rejects_q, orders_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fills_q   <= '0;
      rejects_q <= '0;
      orders_q  <= '0;
    end else begin
      if (fill_vld)               fills_q   <= fills_q + 32'd1;
      if (rsp_vld && rsp_reject)  rejects_q <= rejects_q + 32'd1;
      if (ord_vld && ord_rdy)     orders_q  <= orders_q + 32'd1;
    end
  end

  assign stat_fills_r   = fills_q;
  assign stat_rejects_r = rejects_q;
  assign stat_orders_r  = orders_q;
`endif

endmodule

// File: tb/tb_ob_mk_ctrl.sv
// Testbench for ob_mk_ctrl. It drives directed orders and matches into the DUT. A small
// behavioural deque (depth 4) supplies the status inputs. Expected commands, fills and
// responses are queued before each stimulus, and a negedge monitor pops and compares
// them whenever the DUT presents an output.

module tb_ob_mk_ctrl;

  localparam logic [1:0] OpPushBack  = 2'd0;
  localparam logic [1:0] OpPushFront = 2'd1;
  localparam logic [1:0] OpPopFront  = 2'd3;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ord_vld = 1'b0;
  logic [47:0] ord_data = '0;
  logic        mat_vld = 1'b0;
  logic [15:0] mat_quantity = '0;
  logic        mat_aon = 1'b0;
  logic        ord_rdy, mat_rdy, fill_vld, rsp_vld, rsp_reject, mk_cmd_vld;
  logic [47:0] fill_data, mk_cmd_push_data;
  logic [15:0] rsp_remain;
  logic [1:0]  mk_cmd_op;
  logic        mk_head_vld_r = 1'b0;
  logic [47:0] mk_head_r = '0;
  logic        mk_empty_w = 1'b1;
  logic        mk_full_w = 1'b0;
  logic [23:0] mk_quantity_r = '0;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  logic [49:0] exp_cmd[$];
  logic [47:0] exp_fill[$];
  logic [16:0] exp_rsp[$];
  logic [47:0] dq[$];

  always #5 clk = ~clk;

  ob_mk_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ord_vld          (ord_vld),
    .ord_data         (ord_data),
    .ord_rdy          (ord_rdy),
    .mat_vld          (mat_vld),
    .mat_quantity     (mat_quantity),
    .mat_aon          (mat_aon),
    .mat_rdy          (mat_rdy),
    .fill_vld         (fill_vld),
    .fill_data        (fill_data),
    .rsp_vld          (rsp_vld),
    .rsp_reject       (rsp_reject),
    .rsp_remain       (rsp_remain),
    .mk_cmd_vld       (mk_cmd_vld),
    .mk_cmd_op        (mk_cmd_op),
    .mk_cmd_push_data (mk_cmd_push_data),
    .mk_head_vld_r    (mk_head_vld_r),
    .mk_head_r        (mk_head_r),
    .mk_empty_w       (mk_empty_w),
    .mk_full_w        (mk_full_w),
    .mk_quantity_r    (mk_quantity_r)
  );

  function automatic logic [47:0] ent(input logic [15:0] id, input logic [15:0] px,
                                      input logic [15:0] q);
    return {id, px, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Behavioural deque: status reflects each command from the following cycle.
  always @(posedge clk) begin : dq_model
    logic [23:0] s;
    if (mk_cmd_vld) begin
      case (mk_cmd_op)
        OpPushBack:  if (dq.size() < Depth) dq.push_back(mk_cmd_push_data);
                     else fail_now("deque_pushback_overflow");
        OpPushFront: if (dq.size() < Depth) dq.push_front(mk_cmd_push_data);
                     else fail_now("deque_pushfront_overflow");
        OpPopFront:  if (dq.size() > 0) void'(dq.pop_front());
                     else fail_now("deque_pop_underflow");
        default:     fail_now("deque_illegal_op");
      endcase
    end
    s = '0;
    foreach (dq[i]) s = s + {8'd0, dq[i][15:0]};
    mk_quantity_r <= s;
    mk_head_vld_r <= (dq.size() != 0);
    mk_head_r     <= (dq.size() != 0) ? dq[0] : 48'd0;
    mk_empty_w    <= (dq.size() == 0);
    mk_full_w     <= (dq.size() >= Depth);
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mk_cmd_vld) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected actual op=%0d data=%0h required=none",
                 mk_cmd_op, mk_cmd_push_data);
      end else begin
        logic [49:0] e;
        e = exp_cmd.pop_front();
        chk("cmd_op", {62'd0, mk_cmd_op}, {62'd0, e[49:48]});
        if (e[49:48] != OpPopFront) chk("cmd_push_data", {16'd0, mk_cmd_push_data},
                                        {16'd0, e[47:0]});
      end
    end
    if (fill_vld) begin
      if (exp_fill.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fill_unexpected actual=%0h required=none", fill_data);
      end else begin
        chk("fill_data", {16'd0, fill_data}, {16'd0, exp_fill.pop_front()});
      end
    end
    if (rsp_vld) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual rej=%0d remain=%0d required=none",
                 rsp_reject, rsp_remain);
      end else begin
        chk("rsp_reject_remain", {47'd0, rsp_reject, rsp_remain},
            {47'd0, exp_rsp.pop_front()});
      end
    end
    if (ord_rdy) chk("ord_rdy_only_when_idle", {63'd0, mat_rdy}, 64'd1);
  end

  task automatic exp_pop_fill(input logic [47:0] f);
    exp_cmd.push_back({OpPopFront, 48'd0});
    exp_fill.push_back(f);
  endtask

  task automatic send_order(input logic [47:0] d);
    int n;
    exp_cmd.push_back({OpPushBack, d});
    @(posedge clk);
    #1;
    ord_vld  = 1'b1;
    ord_data = d;
    @(negedge clk);
    n = 0;
    while (!ord_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ord_rdy) fail_now("order_accept_timeout");
    @(posedge clk);
    #1 ord_vld = 1'b0;
  endtask

  task automatic do_match(input logic [15:0] q, input logic aon, output int lat);
    int n;
    int c0;
    @(posedge clk);
    #1;
    mat_vld      = 1'b1;
    mat_quantity = q;
    mat_aon      = aon;
    @(negedge clk);
    n = 0;
    while (!mat_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mat_rdy) fail_now("match_accept_timeout");
    @(posedge clk);
    #1;
    mat_vld = 1'b0;
    c0      = rsp_cnt;
    lat     = 0;
    while (rsp_cnt == c0 && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (rsp_cnt == c0) fail_now("match_rsp_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int c0;
    logic [47:0] e7;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ord_rdy", {63'd0, ord_rdy}, 64'd0);
    chk("reset_mat_rdy", {63'd0, mat_rdy}, 64'd0);
    chk("reset_vlds", {61'd0, fill_vld, rsp_vld, mk_cmd_vld}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Enqueue 5,3 then drain fully with match 8
    send_order(ent(16'd1, 16'd100, 16'd5));
    send_order(ent(16'd2, 16'd101, 16'd3));
    @(negedge clk);
    chk("t1_quantity", {40'd0, mk_quantity_r}, 64'd8);
    exp_pop_fill(ent(16'd1, 16'd100, 16'd5));
    exp_pop_fill(ent(16'd2, 16'd101, 16'd3));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd8, 1'b0, lat);
    @(negedge clk);
    chk("t1_empty", {63'd0, mk_empty_w}, 64'd1);

    // Partial head consumption: PopFront then PushFront of residual 6
    send_order(ent(16'd3, 16'd102, 16'd10));
    exp_pop_fill(ent(16'd3, 16'd102, 16'd4));
    exp_cmd.push_back({OpPushFront, ent(16'd3, 16'd102, 16'd6)});
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd4, 1'b0, lat);
    chk("t2_latency", lat, 64'd4);
    @(negedge clk);
    chk("t2_head", {16'd0, mk_head_r}, {16'd0, ent(16'd3, 16'd102, 16'd6)});
    chk("t2_quantity", {40'd0, mk_quantity_r}, 64'd6);
    exp_pop_fill(ent(16'd3, 16'd102, 16'd6));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd6, 1'b0, lat);

    // AON reject: 7 requested, only 3 queued
    send_order(ent(16'd4, 16'd103, 16'd3));
    exp_rsp.push_back({1'b1, 16'd7});
    do_match(16'd7, 1'b1, lat);
    @(negedge clk);
    chk("t3_quantity", {40'd0, mk_quantity_r}, 64'd3);
    exp_pop_fill(ent(16'd4, 16'd103, 16'd3));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd3, 1'b0, lat);

    // Empty deque, non-AON: nothing filled
    exp_rsp.push_back({1'b0, 16'd5});
    do_match(16'd5, 1'b0, lat);
    // Zero-quantity match: response after CHECK, no command
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd0, 1'b0, lat);
    chk("t4_zero_latency", lat, 64'd2);
    // Insufficient liquidity, non-AON: fill 2, remain 3
    send_order(ent(16'd5, 16'd104, 16'd2));
    exp_pop_fill(ent(16'd5, 16'd104, 16'd2));
    exp_rsp.push_back({1'b0, 16'd3});
    do_match(16'd5, 1'b0, lat);
    @(negedge clk);
    chk("t4_empty", {63'd0, mk_empty_w}, 64'd1);
    // AON exactly satisfiable
    send_order(ent(16'd6, 16'd105, 16'd4));
    exp_pop_fill(ent(16'd6, 16'd105, 16'd4));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd4, 1'b1, lat);

    // Order and match in the same cycle: match wins
    e7 = ent(16'd7, 16'd106, 16'd7);
    exp_cmd.push_back({OpPushBack, e7});
    exp_rsp.push_back({1'b0, 16'd2});
    @(posedge clk);
    #1;
    ord_vld      = 1'b1;
    ord_data     = e7;
    mat_vld      = 1'b1;
    mat_quantity = 16'd2;
    mat_aon      = 1'b0;
    c0           = rsp_cnt;
    @(negedge clk);
    chk("t5_ord_rdy_blocked", {63'd0, ord_rdy}, 64'd0);
    chk("t5_mat_rdy", {63'd0, mat_rdy}, 64'd1);
    @(posedge clk);
    #1 mat_vld = 1'b0;
    n = 0;
    @(negedge clk);
    #1;
    while (!ord_rdy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_rsp_before_order", rsp_cnt - c0, 64'd1);
    @(posedge clk);
    #1 ord_vld = 1'b0;

    // Fill deque to depth, then orders are blocked
    send_order(ent(16'd8, 16'd107, 16'd1));
    send_order(ent(16'd9, 16'd107, 16'd1));
    send_order(ent(16'd10, 16'd107, 16'd1));
    @(negedge clk);
    chk("t5_full", {63'd0, mk_full_w}, 64'd1);
    ord_vld  = 1'b1;
    ord_data = ent(16'd11, 16'd107, 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_ord_rdy_full", {63'd0, ord_rdy}, 64'd0);
    end
    ord_vld = 1'b0;
    exp_pop_fill(e7);
    exp_pop_fill(ent(16'd8, 16'd107, 16'd1));
    exp_pop_fill(ent(16'd9, 16'd107, 16'd1));
    exp_pop_fill(ent(16'd10, 16'd107, 16'd1));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd10, 1'b0, lat);

    // Reset while in DRAIN: match abandoned, no response
    send_order(ent(16'd12, 16'd108, 16'd4));
    send_order(ent(16'd13, 16'd108, 16'd4));
    @(posedge clk);
    #1;
    mat_vld      = 1'b1;
    mat_quantity = 16'd8;
    mat_aon      = 1'b0;
    @(negedge clk);
    chk("t6_mat_rdy", {63'd0, mat_rdy}, 64'd1);
    @(posedge clk);
    #1 mat_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    c0    = rsp_cnt;
    @(negedge clk);
    chk("t6_vlds_in_reset", {61'd0, fill_vld, rsp_vld, mk_cmd_vld}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_reset", {63'd0, mat_rdy}, 64'd1);
    chk("t6_vlds_after_reset", {61'd0, fill_vld, rsp_vld, mk_cmd_vld}, 64'd0);
    chk("t6_quantity", {40'd0, mk_quantity_r}, 64'd8);
    chk("t6_no_rsp", rsp_cnt - c0, 64'd0);
    exp_pop_fill(ent(16'd12, 16'd108, 16'd4));
    exp_pop_fill(ent(16'd13, 16'd108, 16'd4));
    exp_rsp.push_back({1'b0, 16'd0});
    do_match(16'd8, 1'b0, lat);

    repeat (3) @(negedge clk);
    chk("left_cmd", exp_cmd.size(), 64'd0);
    chk("left_fill", exp_fill.size(), 64'd0);
    chk("left_rsp", exp_rsp.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
